// File: rtl/spi_port_scheduler_pkg.sv
// Shared types and constants for the SPI port scheduler: FSM state encoding,
// byte geometry and a small index helper used by the round-robin arbiter.
package spi_sched_pkg;

   localparam int BYTE_W       = 8;
   localparam int HALF_PERIODS = 2 * BYTE_W;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE,
      GAP
   } sched_state_t;

   // Successor of idx in a ring of 'modulus' entries.
   function automatic int wrapIncrement(input int idx, input int modulus);
      return (idx + 1 >= modulus) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/spi_port_scheduler_if.sv
// Client-side request/response channel of the SPI port scheduler.
// 'master' is the client view, 'slave' is the scheduler view.
interface spi_port_scheduler_if
   import spi_sched_pkg::*;
   #(parameter int REQUESTERS = 2);

   logic [REQUESTERS-1:0]        io_req_valid;
   logic [BYTE_W*REQUESTERS-1:0] io_req_data;
   logic [REQUESTERS-1:0]        io_req_last;
   logic [REQUESTERS-1:0]        io_req_ready;
   logic [REQUESTERS-1:0]        io_rsp_valid;
   logic [BYTE_W-1:0]            io_rsp_data;
   logic [REQUESTERS-1:0]        io_grant;

   modport master (
      output io_req_valid,
      output io_req_data,
      output io_req_last,
      input  io_req_ready,
      input  io_rsp_valid,
      input  io_rsp_data,
      input  io_grant
   );

   modport slave (
      input  io_req_valid,
      input  io_req_data,
      input  io_req_last,
      output io_req_ready,
      output io_rsp_valid,
      output io_rsp_data,
      output io_grant
   );

endinterface

// File: rtl/spi_port_scheduler_shifter.sv
// SPI mode-0 byte shifter: 16 half-periods of CLK_DIV cycles, MOSI MSB first,
// MISO sampled on each SCLK rise, SCLK parked low between bytes.
module spi_byte_shifter
   import spi_sched_pkg::*;
   #(parameter int CLK_DIV = 4)
   (
      input  logic              i_clk,
      input  logic              i_rst,
      input  logic              i_start,
      input  logic [BYTE_W-1:0] i_txByte,
      input  logic              i_miso,
      output logic              o_sclk,
      output logic              o_mosi,
      output logic              o_done,
      output logic [BYTE_W-1:0] o_rxByte
   );

   localparam int            CW      = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
   localparam logic [3:0]    IDX_MAX = 4'(HALF_PERIODS - 1);

   logic              r_active;
   logic              r_sclk;
   logic [CW-1:0]     r_cnt;
   logic [3:0]        r_idx;
   logic [BYTE_W-1:0] r_tx;
   logic [BYTE_W-1:0] r_rx;
   logic              w_halfEnd;

   assign w_halfEnd = r_active && (r_cnt == CNT_MAX);

   // A rising half-period end samples MISO; a falling one advances MOSI.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_active <= 1'b0;
         r_sclk   <= 1'b0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_tx     <= '0;
         r_rx     <= '0;
      end else if (!r_active) begin
         if (i_start) begin
            r_active <= 1'b1;
            r_sclk   <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_tx     <= i_txByte;
         end
      end else if (w_halfEnd) begin
         r_cnt  <= '0;
         r_idx  <= r_idx + 4'd1;
         r_sclk <= ~r_sclk;
         if (!r_sclk) begin
            r_rx <= {r_rx[BYTE_W-2:0], i_miso};
         end else begin
            r_tx <= {r_tx[BYTE_W-2:0], 1'b0};
         end
         if (r_idx == IDX_MAX) begin
            r_active <= 1'b0;
         end
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_sclk   = r_sclk;
   assign o_mosi   = r_tx[BYTE_W-1];
   assign o_done   = w_halfEnd && (r_idx == IDX_MAX);
   assign o_rxByte = r_rx;

endmodule

// File: rtl/spi_port_scheduler.sv
// Shares one SPI master port between REQUESTERS clients: round-robin grant per
// transaction, chip-select held across bursts, SS_GAP idle cycles between owners.
module spi_port_scheduler
   import spi_sched_pkg::*;
   #(
      parameter int REQUESTERS = 2,
      parameter int CLK_DIV    = 4,
      parameter int SS_GAP     = 2
   )
   (
      input  logic                  io_clock,
      input  logic                  io_reset,
      spi_port_scheduler_if.slave   bus,
      output logic                  io_busy,
      output logic                  io_spi0_ss,
      output logic                  io_spi0_sclk,
      output logic                  io_spi0_mosi,
      input  logic                  io_spi0_miso
   );

   localparam int            IW       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam int            GW       = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(SS_GAP - 1);

   sched_state_t          r_state;
   logic [REQUESTERS-1:0] r_grant;
   logic [IW-1:0]         r_owner;
   logic [IW-1:0]         r_ptr;
   logic                  r_ss;
   logic                  r_last;
   logic [REQUESTERS-1:0] r_rspValid;
   logic [BYTE_W-1:0]     r_rspData;
   logic [GW-1:0]         r_gapCnt;

   logic [IW-1:0]         w_winLo;
   logic [IW-1:0]         w_winHi;
   logic                  w_hiFound;
   logic [IW-1:0]         w_winner;
   logic [REQUESTERS-1:0] w_winGrant;
   logic [BYTE_W-1:0]     w_txByte;
   logic                  w_ownerValid;
   logic                  w_ownerLast;
   logic                  w_start;
   logic                  w_shiftDone;
   logic [BYTE_W-1:0]     w_rxByte;
   logic [IW-1:0]         w_nextPtr;

   // Round-robin: lowest valid index at or above the pointer, else wrap to the lowest valid.
   always_comb begin
      w_winLo   = '0;
      w_winHi   = '0;
      w_hiFound = 1'b0;
      for (int i = REQUESTERS - 1; i >= 0; i--) begin
         if (bus.io_req_valid[i]) begin
            w_winLo = IW'(i);
            if (IW'(i) >= r_ptr) begin
               w_winHi   = IW'(i);
               w_hiFound = 1'b1;
            end
         end
      end
      w_winner = w_hiFound ? w_winHi : w_winLo;
      for (int i = 0; i < REQUESTERS; i++) begin
         w_winGrant[i] = (IW'(i) == w_winner);
      end
   end

   always_comb begin
      w_txByte     = '0;
      w_ownerValid = 1'b0;
      w_ownerLast  = 1'b0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (r_grant[i]) begin
            w_txByte     = bus.io_req_data[i*BYTE_W +: BYTE_W];
            w_ownerValid = bus.io_req_valid[i];
            w_ownerLast  = bus.io_req_last[i];
         end
      end
   end

   assign w_start   = (r_state == LOAD) && w_ownerValid;
   assign w_nextPtr = IW'(wrapIncrement(int'(r_owner), REQUESTERS));

   spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .i_clk    (io_clock),
      .i_rst    (io_reset),
      .i_start  (w_start),
      .i_txByte (w_txByte),
      .i_miso   (io_spi0_miso),
      .o_sclk   (io_spi0_sclk),
      .o_mosi   (io_spi0_mosi),
      .o_done   (w_shiftDone),
      .o_rxByte (w_rxByte)
   );

   // Transaction FSM; the owner keeps SS low from grant until its last byte completes.
   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_owner    <= '0;
         r_ptr      <= '0;
         r_ss       <= 1'b1;
         r_last     <= 1'b0;
         r_rspValid <= '0;
         r_rspData  <= '0;
         r_gapCnt   <= '0;
      end else begin
         r_rspValid <= '0;
         case (r_state)
            IDLE: begin
               if (|bus.io_req_valid) begin
                  r_grant <= w_winGrant;
                  r_owner <= w_winner;
                  r_ss    <= 1'b0;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               if (w_ownerValid) begin
                  r_last  <= w_ownerLast;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_shiftDone) begin
                  r_rspValid <= r_grant;
                  r_rspData  <= w_rxByte;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (r_last) begin
                  r_ss     <= 1'b1;
                  r_grant  <= '0;
                  r_ptr    <= w_nextPtr;
                  r_gapCnt <= '0;
                  r_state  <= GAP;
               end else begin
                  r_state <= LOAD;
               end
            end
            GAP: begin
               if (r_gapCnt == GAP_LAST) begin
                  r_state <= IDLE;
               end else begin
                  r_gapCnt <= r_gapCnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.io_req_ready = (r_state == LOAD) ? r_grant : '0;
   assign bus.io_rsp_valid = r_rspValid;
   assign bus.io_rsp_data  = r_rspData;
   assign bus.io_grant     = r_grant;
   assign io_busy          = (r_state != IDLE);
   assign io_spi0_ss       = r_ss;

endmodule
